// File: rtl/rgb_sram_packer.sv
`default_nettype none
// ============================================================================
// Module   : rgb_sram_packer
// Brief    : Clips CSC pixels to 8 bits, packs two RGB pixels into three
//            16-bit SRAM words and writes them over the frame's RGB region.
// Revision : 1.0  initial release
// ============================================================================

module rgb_sram_packer #(
    parameter logic [17:0] BASE_ADDR  = 18'd146944,
    parameter int          NUM_PIXELS = 76800
) (
    input  logic        clock_50,
    input  logic        reset,
    input  logic        start,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [31:0] R_in,
    input  logic [31:0] G_in,
    input  logic [31:0] B_in,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        busy,
    output logic        done
);

    localparam logic [16:0] c_num_pixels = 17'(NUM_PIXELS);

    // Pixel pairs must fill whole word triplets and the region must fit in SRAM.
    if ((NUM_PIXELS % 2) != 0 || NUM_PIXELS <= 0) begin : g_bad_num_pixels
        $fatal(1, "rgb_sram_packer: NUM_PIXELS must be positive and even");
    end
    if ((int'(BASE_ADDR) + (3 * NUM_PIXELS) / 2) > 262144) begin : g_bad_region
        $fatal(1, "rgb_sram_packer: RGB region exceeds the 18-bit SRAM space");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_P0 = 3'd1,
        S_WAIT_P1 = 3'd2,
        S_WR0     = 3'd3,
        S_WR1     = 3'd4,
        S_WR2     = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [17:0] r_addr;
    logic [16:0] r_pix_cnt;
    logic [16:0] w_pix_cnt_inc;
    logic        w_last_pair;
    logic        w_transfer;

    logic [7:0]  r_p0_r, r_p0_g, r_p0_b;
    logic [7:0]  r_p1_r, r_p1_g, r_p1_b;

    logic [17:0] r_sram_address;
    logic [15:0] r_sram_write_data;
    logic        r_sram_we_n;
    logic        r_busy;
    logic        r_done;

    function automatic logic [7:0] clip8(input logic [31:0] value);
        if ($signed(value) < 32'sd0) begin
            return 8'd0;
        end else if ($signed(value) > 32'sd255) begin
            return 8'hFF;
        end else begin
            return value[7:0];
        end
    endfunction

    assign pix_ready     = (r_state == S_WAIT_P0) || (r_state == S_WAIT_P1);
    assign w_transfer    = pix_valid && pix_ready;
    assign w_pix_cnt_inc = r_pix_cnt + 17'd2;
    // Pixel count only advances leaving S_WR2, so this is valid throughout a pair.
    assign w_last_pair   = (w_pix_cnt_inc == c_num_pixels);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (start)      w_next_state = S_WAIT_P0;
            S_WAIT_P0: if (w_transfer) w_next_state = S_WAIT_P1;
            S_WAIT_P1: if (w_transfer) w_next_state = S_WR0;
            S_WR0:     w_next_state = S_WR1;
            S_WR1:     w_next_state = S_WR2;
            S_WR2:     w_next_state = w_last_pair ? S_DONE : S_WAIT_P0;
            S_DONE:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_addr            <= 18'd0;
            r_pix_cnt         <= 17'd0;
            r_p0_r            <= 8'd0;
            r_p0_g            <= 8'd0;
            r_p0_b            <= 8'd0;
            r_p1_r            <= 8'd0;
            r_p1_g            <= 8'd0;
            r_p1_b            <= 8'd0;
            r_sram_address    <= 18'd0;
            r_sram_write_data <= 16'd0;
            r_sram_we_n       <= 1'b1;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (r_state == S_DONE);

            if (r_state == S_IDLE && start) begin
                r_addr    <= BASE_ADDR;
                r_pix_cnt <= 17'd0;
                r_busy    <= 1'b1;
            end
            if (r_state == S_DONE) begin
                r_busy <= 1'b0;
            end

            if (r_state == S_WAIT_P0 && w_transfer) begin
                r_p0_r <= clip8(R_in);
                r_p0_g <= clip8(G_in);
                r_p0_b <= clip8(B_in);
            end
            if (r_state == S_WAIT_P1 && w_transfer) begin
                r_p1_r <= clip8(R_in);
                r_p1_g <= clip8(G_in);
                r_p1_b <= clip8(B_in);
            end

            if (r_state == S_WR2) begin
                r_pix_cnt <= w_pix_cnt_inc;
            end

            // SRAM outputs are loaded from the next state so each write cycle
            // sees its address/data/we_n already registered and stable.
            r_sram_we_n <= 1'b1;
            if (w_next_state == S_WR0 || w_next_state == S_WR1 || w_next_state == S_WR2) begin
                r_sram_we_n    <= 1'b0;
                r_sram_address <= r_addr;
                // The final write of a frame leaves the counter on the last word.
                if (!(w_next_state == S_WR2 && w_last_pair)) begin
                    r_addr <= r_addr + 18'd1;
                end
            end
            case (w_next_state)
                S_WR0:   r_sram_write_data <= {r_p0_r, r_p0_g};
                S_WR1:   r_sram_write_data <= {r_p0_b, r_p1_r};
                S_WR2:   r_sram_write_data <= {r_p1_g, r_p1_b};
                default: r_sram_write_data <= r_sram_write_data;
            endcase
        end
    end

    assign SRAM_address    = r_sram_address;
    assign SRAM_write_data = r_sram_write_data;
    assign SRAM_we_n       = r_sram_we_n;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule

`default_nettype wire

// File: tb/tb_rgb_sram_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_sram_packer
// Brief    : Randomised self-checking bench for rgb_sram_packer against a
//            pixel-list / word-queue reference model.
// Revision : 1.0  initial release
// ============================================================================

module tb_rgb_sram_packer;

    // Scaled frame placed so its last word lands on the top SRAM address 262143.
    localparam int          N     = 400;
    localparam int          WORDS = (3 * N) / 2;
    localparam logic [17:0] BASE  = 18'(262144 - WORDS);

    logic        clock_50 = 1'b0;
    logic        reset;
    logic        start;
    logic        pix_valid;
    logic        pix_ready;
    logic [31:0] R_in, G_in, B_in;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        busy;
    logic        done;

    rgb_sram_packer #(
        .BASE_ADDR  (BASE),
        .NUM_PIXELS (N)
    ) dut (
        .clock_50        (clock_50),
        .reset           (reset),
        .start           (start),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .R_in            (R_in),
        .G_in            (G_in),
        .B_in            (B_in),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .busy            (busy),
        .done            (done)
    );

    always #10 clock_50 = ~clock_50;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: clipped channel bytes accumulate until a pair is complete,
    // then the three packed words are queued in write order.
    int          pend[$];
    logic [15:0] exp_q[$];
    int          wr_idx;
    int          wr_count[WORDS];
    int          out_of_range;
    int          spurious;
    int          last_addr;
    int          done_count;

    function automatic int clip(input int v);
        if (v < 0)   return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    task automatic model_accept(input int r, input int g, input int b);
        pend.push_back(clip(r));
        pend.push_back(clip(g));
        pend.push_back(clip(b));
        if (pend.size() == 6) begin
            exp_q.push_back(16'(pend[0] * 256 + pend[1]));
            exp_q.push_back(16'(pend[2] * 256 + pend[3]));
            exp_q.push_back(16'(pend[4] * 256 + pend[5]));
            pend.delete();
        end
    endtask

    task automatic model_clear();
        pend.delete();
        exp_q.delete();
        wr_idx       = 0;
        out_of_range = 0;
        spurious     = 0;
        last_addr    = -1;
        done_count   = 0;
        for (int i = 0; i < WORDS; i++) wr_count[i] = 0;
    endtask

    always @(negedge clock_50) begin
        if (reset === 1'b0) begin
            if (SRAM_we_n === 1'b0) begin
                if (SRAM_address < BASE || int'(SRAM_address) > int'(BASE) + WORDS - 1)
                    out_of_range++;
                else
                    wr_count[int'(SRAM_address) - int'(BASE)]++;
                last_addr = int'(SRAM_address);
                if (exp_q.size() == 0) begin
                    spurious++;
                end else begin
                    check_eq("wr_addr", 32'(SRAM_address), 32'(int'(BASE) + wr_idx));
                    check_eq("wr_data", 32'(SRAM_write_data), 32'(exp_q.pop_front()));
                end
                wr_idx++;
            end
            if (done === 1'b1) done_count++;
        end
    end

    // Callers enter and leave every task 1 time unit after a rising edge.
    task automatic send_pixel(input int r, input int g, input int b, input bit stall);
        bit acc = 1'b0;
        int budget = 0;
        while (!acc && budget < 200) begin
            pix_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            R_in = r;
            G_in = g;
            B_in = b;
            @(negedge clock_50);
            acc = pix_valid && pix_ready;
            if (acc) model_accept(r, g, b);
            @(posedge clock_50);
            #1;
            budget++;
        end
        pix_valid = 1'b0;
        if (!acc) check_eq("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic rand_pix(output int r, output int g, output int b);
        r = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 700)) - 200;
        g = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 700)) - 200;
        b = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 700)) - 200;
    endtask

    task automatic expect_three(input logic [15:0] w0, input logic [15:0] w1,
                                input logic [15:0] w2, input int off);
        logic [15:0] w[3];
        w[0] = w0;
        w[1] = w1;
        w[2] = w2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock_50);
            check_eq("fixed_we_n", 32'(SRAM_we_n), 32'd0);
            check_eq("fixed_addr", 32'(SRAM_address), 32'(int'(BASE) + off + k));
            check_eq("fixed_data", 32'(SRAM_write_data), 32'(w[k]));
            check_eq("ready_in_wr", 32'(pix_ready), 32'd0);
        end
        @(posedge clock_50);
        #1;
    endtask

    task automatic start_frame();
        model_clear();
        start = 1'b1;
        @(posedge clock_50);
        #1;
        start = 1'b0;
        @(negedge clock_50);
        check_eq("busy_after_start", 32'(busy), 32'd1);
        @(posedge clock_50);
        #1;
    endtask

    task automatic finish_frame();
        int k;
        for (k = 1; k <= 20; k++) begin
            @(negedge clock_50);
            if (done === 1'b1) break;
        end
        check_eq("done_latency", 32'(k), 32'd5);
        @(negedge clock_50);
        check_eq("done_pulse_end", 32'(done), 32'd0);
        check_eq("busy_after_done", 32'(busy), 32'd0);
        repeat (3) @(negedge clock_50);
        @(posedge clock_50);
        #1;
        begin
            int holes = 0;
            for (int i = 0; i < WORDS; i++) if (wr_count[i] != 1) holes++;
            check_eq("write_once_cover", 32'(holes), 32'd0);
        end
        check_eq("out_of_range", 32'(out_of_range), 32'd0);
        check_eq("spurious_write", 32'(spurious), 32'd0);
        check_eq("last_addr", 32'(last_addr), 32'd262143);
        check_eq("done_count", 32'(done_count), 32'd1);
        check_eq("words_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, g, b;
        model_clear();
        reset     = 1'b1;
        start     = 1'b1;
        pix_valid = 1'b0;
        R_in      = '0;
        G_in      = '0;
        B_in      = '0;

        // Reset together with start: reset must win.
        repeat (3) @(posedge clock_50);
        @(negedge clock_50);
        check_eq("rst_we_n", 32'(SRAM_we_n), 32'd1);
        check_eq("rst_addr", 32'(SRAM_address), 32'd0);
        check_eq("rst_data", 32'(SRAM_write_data), 32'd0);
        check_eq("rst_ready", 32'(pix_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        @(posedge clock_50);
        #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock_50);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_ready", 32'(pix_ready), 32'd0);
        @(posedge clock_50);
        #1;

        // Frame 1: clip pair, fixed pair, stalled pairs, start pulses mid-frame.
        start_frame();
        send_pixel(-5, 300, 128, 1'b0);
        send_pixel(255, 0, 1000, 1'b0);
        expect_three(16'h00FF, 16'h80FF, 16'h00FF, 0);
        send_pixel(32'h12, 32'h34, 32'h56, 1'b0);
        send_pixel(32'h78, 32'h9A, 32'hBC, 1'b0);
        expect_three(16'h1234, 16'h5678, 16'h9ABC, 3);
        for (int p = 0; p < N / 2 - 2; p++) begin
            rand_pix(r, g, b);
            send_pixel(r, g, b, 1'b1);
            if (p == 12) begin
                start = 1'b1;
                @(posedge clock_50);
                #1;
                start = 1'b0;
            end
            rand_pix(r, g, b);
            send_pixel(r, g, b, 1'b1);
            if (p == 12) begin
                repeat (2) begin
                    @(posedge clock_50);
                    #1;
                end
                start = 1'b1;
                @(posedge clock_50);
                #1;
                start = 1'b0;
            end
        end
        finish_frame();

        // Reset during the second write of a pair.
        start_frame();
        rand_pix(r, g, b);
        send_pixel(r, g, b, 1'b0);
        rand_pix(r, g, b);
        send_pixel(r, g, b, 1'b0);
        @(posedge clock_50);
        #1;
        reset = 1'b1;
        @(posedge clock_50);
        #1;
        reset = 1'b0;
        model_clear();
        @(negedge clock_50);
        check_eq("midrst_we_n", 32'(SRAM_we_n), 32'd1);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_ready", 32'(pix_ready), 32'd0);
        @(posedge clock_50);
        #1;

        // Frame 2: full random frame must restart from BASE.
        start_frame();
        for (int p = 0; p < N; p++) begin
            rand_pix(r, g, b);
            send_pixel(r, g, b, 1'b1);
        end
        finish_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
